// File: rtl/wb_conmax_slave_port.sv
// WISHBONE connection-matrix slave port: arbitrates NM masters onto one slave by
// priority level with round-robin tie-break, holds the grant per bus cycle, and has a watchdog.
module wb_conmax_slave_port #(
    parameter int NM   = 8,
    parameter int MW   = 3,
    parameter int aw   = 32,
    parameter int dw   = 32,
    parameter int sw   = dw / 8,
    parameter int PW   = 2,
    parameter int TO_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NM*PW-1:0]   conf,
    input  logic [TO_W-1:0]    to_val,
    input  logic [dw-1:0]      wb_data_i,
    output logic [dw-1:0]      wb_data_o,
    output logic [aw-1:0]      wb_addr_o,
    output logic [sw-1:0]      wb_sel_o,
    output logic               wb_we_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_rty_i,
    input  logic [NM*dw-1:0]   m_data_i,
    input  logic [NM*aw-1:0]   m_addr_i,
    input  logic [NM*sw-1:0]   m_sel_i,
    input  logic [NM-1:0]      m_we_i,
    input  logic [NM-1:0]      m_cyc_i,
    input  logic [NM-1:0]      m_stb_i,
    output logic [dw-1:0]      m_data_o,
    output logic [NM-1:0]      m_ack_o,
    output logic [NM-1:0]      m_err_o,
    output logic [NM-1:0]      m_rty_o,
    output logic               gnt_vld_o,
    output logic [MW-1:0]      gnt_idx_o,
    output logic               to_evt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_DROP
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [MW-1:0]   r_gntIdx;
    logic [MW-1:0]   r_lastGnt;
    logic [TO_W-1:0] r_cnt;

    logic [MW-1:0]   w_winner;
    logic [MW-1:0]   w_cand;
    logic [PW-1:0]   w_bestPri;
    logic            w_found;
    int              w_sum;
    logic            w_anyReq;
    logic            w_own;
    logic            w_ownerCyc;
    logic            w_stbOut;
    logic            w_term;
    logic            w_toErr;

    assign w_anyReq   = |m_cyc_i;
    assign w_own      = (r_state == ST_OWN) && !rst_i;
    assign w_ownerCyc = m_cyc_i[r_gntIdx];
    assign w_stbOut   = w_own && m_stb_i[r_gntIdx];
    assign w_term     = wb_ack_i | wb_err_i | wb_rty_i;
    assign w_toErr    = w_stbOut && !w_term && (to_val != '0) && (r_cnt == to_val - TO_W'(1));

    // Scan requesters in circular order starting after the last owner; a strictly
    // higher level is needed to displace an earlier candidate, so ties go to the first seen.
    always_comb begin
        w_winner  = '0;
        w_bestPri = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        w_sum     = 0;
        for (int k = 1; k <= NM; k++) begin
            w_sum = int'(r_lastGnt) + k;
            if (w_sum >= NM) begin
                w_sum = w_sum - NM;
            end
            w_cand = w_sum[MW-1:0];
            if (m_cyc_i[w_cand] && (!w_found || conf[int'(w_cand)*PW +: PW] > w_bestPri)) begin
                w_found   = 1'b1;
                w_winner  = w_cand;
                w_bestPri = conf[int'(w_cand)*PW +: PW];
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_anyReq) w_nextState = ST_OWN;
            ST_OWN: begin
                if (!w_ownerCyc) begin
                    w_nextState = ST_IDLE;
                end else if (w_toErr) begin
                    w_nextState = ST_DROP;
                end
            end
            ST_DROP: if (!w_ownerCyc) w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_gntIdx  <= '0;
            r_lastGnt <= MW'(NM - 1);
            r_cnt     <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_IDLE && w_anyReq) begin
                r_gntIdx <= w_winner;
            end
            if (r_state != ST_IDLE && !w_ownerCyc) begin
                r_lastGnt <= r_gntIdx;
            end
            // Saturate so a disabled watchdog never wraps back into a false match.
            if (!w_stbOut || w_term) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + TO_W'(1);
            end
        end
    end

    assign wb_data_o = m_data_i[int'(r_gntIdx)*dw +: dw];
    assign wb_addr_o = m_addr_i[int'(r_gntIdx)*aw +: aw];
    assign wb_sel_o  = m_sel_i[int'(r_gntIdx)*sw +: sw];
    assign wb_we_o   = m_we_i[r_gntIdx];
    assign m_data_o  = wb_data_i;
    assign gnt_vld_o = w_own;
    assign gnt_idx_o = r_gntIdx;

    // Terminations reach only the owner, and only while it owns; DROP swallows late responses.
    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        m_ack_o  = '0;
        m_err_o  = '0;
        m_rty_o  = '0;
        to_evt_o = 1'b0;
        if (w_own) begin
            wb_cyc_o           = w_ownerCyc;
            wb_stb_o           = w_stbOut;
            m_ack_o[r_gntIdx]  = wb_ack_i;
            m_rty_o[r_gntIdx]  = wb_rty_i;
            m_err_o[r_gntIdx]  = wb_err_i | w_toErr;
            to_evt_o           = w_toErr;
        end
    end

endmodule

// File: tb/tb_wb_conmax_slave_port.sv
// Self-checking bench for wb_conmax_slave_port: expected grant order goes into a
// scoreboard queue when requests are driven and is popped when the DUT grants.
module tb_wb_conmax_slave_port;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [15:0]  conf;
    logic [7:0]   to_val;
    logic [31:0]  wb_data_i;
    logic [31:0]  wb_data_o;
    logic [31:0]  wb_addr_o;
    logic [3:0]   wb_sel_o;
    logic         wb_we_o;
    logic         wb_cyc_o;
    logic         wb_stb_o;
    logic         wb_ack_i;
    logic         wb_err_i;
    logic         wb_rty_i;
    logic [255:0] m_data_i;
    logic [255:0] m_addr_i;
    logic [31:0]  m_sel_i;
    logic [7:0]   m_we_i;
    logic [7:0]   m_cyc_i;
    logic [7:0]   m_stb_i;
    logic [31:0]  m_data_o;
    logic [7:0]   m_ack_o;
    logic [7:0]   m_err_o;
    logic [7:0]   m_rty_o;
    logic         gnt_vld_o;
    logic [2:0]   gnt_idx_o;
    logic         to_evt_o;

    int checks   = 0;
    int failures = 0;
    int expQ[$];

    wb_conmax_slave_port dut (
        .clk_i(clk), .rst_i(rst_i), .conf(conf), .to_val(to_val),
        .wb_data_i(wb_data_i), .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .m_data_i(m_data_i), .m_addr_i(m_addr_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_data_o(m_data_o),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .gnt_vld_o(gnt_vld_o), .gnt_idx_o(gnt_idx_o), .to_evt_o(to_evt_o)
    );

    always #5 clk = ~clk;

    task automatic idle_all();
        m_cyc_i  = '0;
        m_stb_i  = '0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1;
        idle_all();
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    // Waits (bounded) for a grant and compares its index to the scoreboard head.
    task automatic wait_grant();
        bit seen;
        int exp;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (gnt_vld_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL grant_scoreboard_empty actual=%0d required=none", gnt_idx_o);
        end else begin
            exp = expQ.pop_front();
            if (!seen) begin
                failures++;
                $display("[TB] FAIL grant_timeout actual=no_grant required=%0d", exp);
            end else if (gnt_idx_o !== exp[2:0]) begin
                failures++;
                $display("[TB] FAIL grant_idx actual=%0d required=%0d", gnt_idx_o, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wb_cyc_o, wb_stb_o, gnt_vld_o, to_evt_o} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl actual=%b required=0000", {wb_cyc_o, wb_stb_o, gnt_vld_o, to_evt_o});
        end
        checks++;
        if ({m_ack_o, m_err_o, m_rty_o} !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_term actual=%h required=000000", {m_ack_o, m_err_o, m_rty_o});
        end
        checks++;
        if (gnt_idx_o !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_gnt_idx actual=%0d required=0", gnt_idx_o);
        end
        checks++;
        if (wb_addr_o !== 32'h0000_1000) begin
            failures++;
            $display("[TB] FAIL reset_addr_mux actual=%h required=00001000", wb_addr_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        conf   = '0;
        to_val = 8'd0;
        m_cyc_i[2] = 1'b1;
        m_stb_i[2] = 1'b1;
        m_we_i[2]  = 1'b0;
        expQ.push_back(2);
        @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_latency actual=%b required=0", wb_cyc_o);
        end
        wait_grant();
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL basic_ctrl actual=%b required=110", {wb_cyc_o, wb_stb_o, wb_we_o});
        end
        checks++;
        if (wb_addr_o !== 32'h0000_0100 || wb_data_o !== 32'hDEAD_0002 || wb_sel_o !== 4'b1010) begin
            failures++;
            $display("[TB] FAIL basic_mux actual=%h/%h/%b required=00000100/dead0002/1010",
                     wb_addr_o, wb_data_o, wb_sel_o);
        end
        @(negedge clk);
        @(posedge clk); #1;
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (m_ack_o !== 8'h04 || m_err_o !== 8'h00 || m_rty_o !== 8'h00) begin
            failures++;
            $display("[TB] FAIL basic_ack actual=%h/%h/%h required=04/00/00", m_ack_o, m_err_o, m_rty_o);
        end
        checks++;
        if (m_data_o !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL basic_rdata actual=%h required=12345678", m_data_o);
        end
        @(posedge clk); #1;
        wb_ack_i   = 1'b0;
        m_cyc_i[2] = 1'b0;
        m_stb_i[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_drop_cyc actual=%b required=0", wb_cyc_o);
        end
        @(negedge clk);
        checks++;
        if (gnt_vld_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_release actual=%b required=0", gnt_vld_o);
        end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        conf    = '0;
        to_val  = 8'd0;
        m_cyc_i = 8'hFF;
        m_stb_i = 8'hFF;
        for (int i = 0; i < 9; i++) expQ.push_back(i % 8);
        for (int i = 0; i < 9; i++) begin
            e = i % 8;
            wait_grant();
            @(posedge clk); #1;
            wb_ack_i = 1'b1;
            @(negedge clk);
            checks++;
            if (m_ack_o !== (8'h01 << e)) begin
                failures++;
                $display("[TB] FAIL rr_ack actual=%h required=%h", m_ack_o, 8'h01 << e);
            end
            @(posedge clk); #1;
            wb_ack_i   = 1'b0;
            m_cyc_i[e] = 1'b0;
            m_stb_i[e] = 1'b0;
            @(negedge clk);
            checks++;
            if (wb_cyc_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rr_drop actual=%b required=0", wb_cyc_o);
            end
            @(posedge clk); #1;
            m_cyc_i[e] = 1'b1;
            m_stb_i[e] = 1'b1;
            @(negedge clk);
            checks++;
            if (wb_cyc_o !== 1'b0 || gnt_vld_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rr_idle_gap actual=%b%b required=00", wb_cyc_o, gnt_vld_o);
            end
        end
        idle_all();
    endtask

    task automatic test_priority();
        do_reset();
        conf    = 16'h0C00;
        to_val  = 8'd0;
        m_cyc_i = 8'h22;
        m_stb_i = 8'h22;
        expQ.push_back(5);
        expQ.push_back(1);
        wait_grant();
        @(posedge clk); #1;
        wb_ack_i = 1'b1;
        @(negedge clk);
        checks++;
        if (m_ack_o !== 8'h20) begin
            failures++;
            $display("[TB] FAIL prio_ack_m5 actual=%h required=20", m_ack_o);
        end
        @(posedge clk); #1;
        wb_ack_i   = 1'b0;
        m_cyc_i[5] = 1'b0;
        m_stb_i[5] = 1'b0;
        @(negedge clk);
        wait_grant();
        @(posedge clk); #1;
        m_cyc_i[5] = 1'b1;
        m_stb_i[5] = 1'b1;
        expQ.push_back(5);
        repeat (3) @(negedge clk);
        checks++;
        if (gnt_vld_o !== 1'b1 || gnt_idx_o !== 3'd1) begin
            failures++;
            $display("[TB] FAIL prio_no_preempt actual=%b/%0d required=1/1", gnt_vld_o, gnt_idx_o);
        end
        @(posedge clk); #1;
        wb_ack_i = 1'b1;
        @(negedge clk);
        checks++;
        if (m_ack_o !== 8'h02) begin
            failures++;
            $display("[TB] FAIL prio_ack_m1 actual=%h required=02", m_ack_o);
        end
        @(posedge clk); #1;
        wb_ack_i   = 1'b0;
        m_cyc_i[1] = 1'b0;
        m_stb_i[1] = 1'b0;
        @(negedge clk);
        wait_grant();
        idle_all();
        conf = '0;
    endtask

    task automatic test_watchdog();
        int errCount;
        do_reset();
        to_val     = 8'd4;
        m_cyc_i[3] = 1'b1;
        m_stb_i[3] = 1'b1;
        expQ.push_back(3);
        wait_grant();
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (c < 4) begin
                if (m_err_o !== 8'h00 || to_evt_o !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL wd_early cycle=%0d actual=%h/%b required=00/0", c, m_err_o, to_evt_o);
                end
                @(negedge clk);
            end else if (m_err_o !== 8'h08 || to_evt_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL wd_expiry actual=%h/%b required=08/1", m_err_o, to_evt_o);
            end
        end
        @(posedge clk); #1;
        wb_ack_i = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b0 || gnt_vld_o !== 1'b0 || m_ack_o !== 8'h00) begin
            failures++;
            $display("[TB] FAIL wd_drop actual=%b/%b/%h required=0/0/00", wb_cyc_o, gnt_vld_o, m_ack_o);
        end
        @(posedge clk); #1;
        wb_ack_i   = 1'b0;
        m_cyc_i[3] = 1'b0;
        m_stb_i[3] = 1'b0;
        repeat (2) @(negedge clk);
        to_val     = 8'd0;
        m_cyc_i[3] = 1'b1;
        m_stb_i[3] = 1'b1;
        expQ.push_back(3);
        wait_grant();
        errCount = 0;
        repeat (1000) begin
            @(negedge clk);
            if (m_err_o !== 8'h00 || to_evt_o !== 1'b0) errCount++;
        end
        checks++;
        if (errCount != 0 || wb_cyc_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wd_disabled actual=%0d/%b required=0/1", errCount, wb_cyc_o);
        end
        idle_all();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_at_expiry();
        do_reset();
        to_val     = 8'd4;
        m_cyc_i[6] = 1'b1;
        m_stb_i[6] = 1'b1;
        expQ.push_back(6);
        wait_grant();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        wb_ack_i = 1'b1;
        @(negedge clk);
        checks++;
        if (m_ack_o !== 8'h40 || m_err_o !== 8'h00 || to_evt_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_ack actual=%h/%h/%b required=40/00/0", m_ack_o, m_err_o, to_evt_o);
        end
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt_vld_o !== 1'b1 || m_err_o !== 8'h00) begin
            failures++;
            $display("[TB] FAIL tie_restart actual=%b/%h required=1/00", gnt_vld_o, m_err_o);
        end
        idle_all();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        to_val     = 8'd10;
        m_cyc_i[4] = 1'b1;
        m_stb_i[4] = 1'b1;
        expQ.push_back(4);
        wait_grant();
        @(negedge clk);
        @(posedge clk); #1;
        rst_i = 1'b1;
        idle_all();
        @(posedge clk); #1;
        rst_i   = 1'b0;
        m_cyc_i = 8'h09;
        m_stb_i = 8'h09;
        expQ.push_back(0);
        @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b0 || gnt_vld_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid actual=%b/%b required=0/0", wb_cyc_o, gnt_vld_o);
        end
        wait_grant();
        idle_all();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_i     = 1'b1;
        conf      = '0;
        to_val    = '0;
        wb_data_i = '0;
        m_we_i    = '0;
        idle_all();
        for (int i = 0; i < 8; i++) begin
            m_addr_i[i*32 +: 32] = 32'h0000_1000 + i;
            m_data_i[i*32 +: 32] = 32'hDEAD_0000 + i;
            m_sel_i[i*4 +: 4]    = 4'(i);
        end
        m_addr_i[2*32 +: 32] = 32'h0000_0100;
        m_sel_i[2*4 +: 4]    = 4'b1010;

        test_reset();
        test_basic();
        test_round_robin();
        test_priority();
        test_watchdog();
        test_ack_at_expiry();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
